psum_requant_packer: RTL
========================

Name: psum_requant_packer

Overview:
- Downstream neighbour of the PE array / adder-tree stage: consumes the 8 x 32-bit signed accumulated output-channel sums and their single-cycle valid pulse.
- Requantizes each channel to int8 using per-channel scale, rounding shift and zero point, with optional ReLU and saturation.
- Packs the 8 bytes into one 64-bit word and buffers it in a small FIFO behind a valid/ready output handshake toward the output SRAM writer.
- The array cannot stall, so input is never back-pressured; overflow is flagged.

Parameters:
- CH, 8, channels per word (equals PE block height).
- ACC_W, 32, accumulator width in bits.
- SCALE_W, 16, unsigned per-channel multiplier width.
- FIFO_DEPTH, 4, output words buffered; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_psum  in  ACC_W x CH  signed partial sums. Element k is channel k.
- i_valid  in  1  single-cycle pulse; i_psum is valid in that cycle.
- i_scale  in  SCALE_W x CH  per-channel unsigned multiplier. Static during operation.
- i_shift  in  5 x CH  per-channel right shift, 0..31. Static.
- i_zp  in  8 x CH  per-channel signed output zero point. Static.
- i_relu  in  1  1 = clamp the lower bound to the zero point. Static.
- i_clr_ovf  in  1  synchronous clear of o_overflow.
- o_data  out  8*CH  packed int8 word. Channel k occupies bits [8k+7:8k].
- o_valid  out  1  FIFO non-empty.
- o_ready  in  1  consumer ready.
- o_overflow  out  1  sticky; a word was dropped.
- o_count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pipeline valid bits cleared; FIFO emptied.
  - o_valid=0, o_data=0, o_overflow=0, o_count=0.
  - A pulse that is in flight when reset hits is discarded.
- S1 register: prod = i_psum * {0, i_scale}, signed, 48 bits (ACC_W+SCALE_W).
- S2 register:
  - If shift = 0: r = prod.
  - Otherwise: r = (prod + 2^(shift-1)) >>> shift. This rounds half toward +inf.
  - Then v = r + sign-extended zp, computed in 49 bits.
- S3 register:
  - lo = i_relu ? max(-128, zp) : -128; hi = 127.
  - Result = clamp(v, lo, hi), truncated to 8 bits, then packed.
- Valid travels with the data through S1..S3. The S3 valid is the FIFO write enable.
- Latency:
  - i_valid in cycle t gives the FIFO write at the end of cycle t+3.
  - With the FIFO empty, o_valid rises in cycle t+4.
  - Throughput is one word per cycle (back-to-back pulses allowed).
- FIFO:
  - Circular buffer with registered read data. o_data shows the head entry.
  - A pop occurs when o_valid & o_ready. o_data is held stable while o_valid=1 and o_ready=0.
  - Push and pop in the same cycle leave o_count unchanged and are legal even when full. No overflow in that case.
  - Push while full with no pop: the word is dropped and o_overflow is set. FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. o_count never exceeds FIFO_DEPTH.
  - Pop while empty is impossible, since o_valid=0.
- o_overflow:
  - Cleared by i_clr_ovf.
  - If i_clr_ovf and a new overflow occur in the same cycle, the overflow wins and the flag stays 1.
- Config inputs are sampled at S1/S2/S3 respectively. Changing them mid-stream is undefined. Controller guarantees they are stable from the first pulse to drain.

Decomposition:
- Shared package (int8 top-level package):
  - Constants: CH, ACC_W, SCALE_W, INT8_MIN = -128, INT8_MAX = 127.
  - Typedefs: psum_t (signed ACC_W), q8_t (signed 8), qword_t (8*CH).
- Sub-module requant_lane: one channel's S1..S3 datapath. Instantiated CH times via generate.
- The FIFO stays inline in the top module.

Test Plan:
- Pass-through: scale=1, shift=0, zp=0, relu=0, psum[k]=10k, pulse in cycle t. Expect o_valid in cycle t+4 and o_data=0x46_3C_32_28_1E_14_0A_00.
- Rounding: scale=1, shift=3. psum=300 -> 38; psum=-300 -> -37 (0xDB); psum=4 -> 1; psum=3 -> 0.
- Saturation/ReLU:
  - relu=0, zp=0: psum=100000 -> 0x7F; psum=-100000 -> 0x80.
  - relu=1, zp=0: psum=-5 -> 0x00.
  - relu=1, zp=10: psum=-5 -> 0x0A.
- Backpressure/overflow: o_ready=0, five pulses with psum[0]=1..5. Expect o_count=4 and o_overflow=1. Release o_ready: words arrive with byte0 = 1,2,3,4 in order, and 5 never appears. i_clr_ovf then gives 0.
- Full + simultaneous pop/push: with 4 entries and o_ready=1 in the same cycle as the S3 write, expect o_count to stay 4 and o_overflow to stay 0.
- Reset mid-pipeline: pulse in cycle t, rst=1 in cycle t+2. Expect o_valid to stay 0 and o_count=0 afterwards; the next pulse is processed normally with 4-cycle latency.

Source files
------------

// File: rtl/psum_requant_packer_pkg.sv
// Shared constants and types for the partial-sum requantize/pack block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_requant_packer_pkg;

  localparam int CH       = 8;
  localparam int ACC_W    = 32;
  localparam int SCALE_W  = 16;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  typedef logic signed [ACC_W-1:0] psum_t;
  typedef logic signed [7:0]       q8_t;
  typedef logic [8*CH-1:0]         qword_t;

endpackage

// File: rtl/psum_requant_packer_lane.sv
// One channel of requantization: scale multiply, rounding shift + zero point, clamp to int8.
// Latency: 3 cycles (S1 product, S2 shifted/offset value, S3 clamped byte).
// Backpressure: none; free-running datapath, valid is tracked by the parent.
//
// Ports: clk; psum (signed accumulator), scale (unsigned multiplier), shift (0..31),
//        zp (signed zero point), relu (raise lower bound to zp); q = int8 result.
module requant_lane #(
  parameter int ACC_W   = psum_requant_packer_pkg::ACC_W,
  parameter int SCALE_W = psum_requant_packer_pkg::SCALE_W
) (
  input  logic                     clk,
  input  logic signed [ACC_W-1:0]  psum,
  input  logic [SCALE_W-1:0]       scale,
  input  logic [4:0]               shift,
  input  logic [7:0]               zp,
  input  logic                     relu,
  output psum_requant_packer_pkg::q8_t q
);
  import psum_requant_packer_pkg::*;

  localparam int PW = ACC_W + SCALE_W;  // product width
  localparam int VW = PW + 1;           // one guard bit for rounding and zp add

  logic signed [PW-1:0] psum_ext, scale_ext, prod_d, prod_q;
  logic signed [VW-1:0] prod_w, rnd, sum, r, zp_ext, v_d, v_q, lo_ext, hi_ext;
  q8_t                  q_d, q_q;

  always_comb begin
    // Scale is unsigned: zero-extend so the signed multiply treats it as positive.
    psum_ext  = {{SCALE_W{psum[ACC_W-1]}}, psum};
    scale_ext = {{ACC_W{1'b0}}, scale};
    prod_d    = psum_ext * scale_ext;
  end

  always_comb begin
    prod_w = {prod_q[PW-1], prod_q};
    // Half-LSB bias before the arithmetic shift gives round-half-up; unused when shift is 0.
    rnd    = {{(VW-1){1'b0}}, 1'b1} << (shift - 5'd1);
    sum    = prod_w + rnd;
    r      = (shift == 5'd0) ? prod_w : (sum >>> shift);
    zp_ext = {{(VW-8){zp[7]}}, zp};
    v_d    = r + zp_ext;
  end

  always_comb begin
    // zp can never be below -128, so max(-128, zp) reduces to zp.
    lo_ext = relu ? zp_ext : VW'(INT8_MIN);
    hi_ext = VW'(INT8_MAX);
    q_d    = v_q[7:0];
    if (v_q < lo_ext)      q_d = lo_ext[7:0];
    else if (v_q > hi_ext) q_d = hi_ext[7:0];
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    v_q    <= v_d;
    q_q    <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/psum_requant_packer.sv
// Requantizes CH accumulator sums to int8, packs them into one word and queues it for the SRAM writer.
// Latency: i_valid in cycle t -> FIFO write end of t+3 -> o_valid in t+4 when the FIFO was empty.
// Backpressure: input never stalls; a word arriving with the FIFO full and no pop is dropped and o_overflow sticks.
//
// Ports: clk, rst (sync, active-high); i_psum/i_valid from the adder tree; i_scale/i_shift/i_zp/i_relu
//        static per-channel config; i_clr_ovf clears o_overflow; o_data/o_valid/o_ready output handshake;
//        o_count FIFO occupancy.
module psum_requant_packer #(
  parameter int CH         = psum_requant_packer_pkg::CH,
  parameter int ACC_W      = psum_requant_packer_pkg::ACC_W,
  parameter int SCALE_W    = psum_requant_packer_pkg::SCALE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CH-1:0][ACC_W-1:0]          i_psum,
  input  logic                              i_valid,
  input  logic [CH-1:0][SCALE_W-1:0]        i_scale,
  input  logic [CH-1:0][4:0]                i_shift,
  input  logic [CH-1:0][7:0]                i_zp,
  input  logic                              i_relu,
  input  logic                              i_clr_ovf,
  output logic [8*CH-1:0]                   o_data,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic                              o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]       o_count
);
  import psum_requant_packer_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic              vld1, vld2, vld3;
  logic [CH-1:0][7:0] lane_q;
  logic [8*CH-1:0]   wdata;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    requant_lane #(.ACC_W(ACC_W), .SCALE_W(SCALE_W)) u_lane (
      .clk   (clk),
      .psum  (i_psum[k]),
      .scale (i_scale[k]),
      .shift (i_shift[k]),
      .zp    (i_zp[k]),
      .relu  (i_relu),
      .q     (lane_q[k])
    );
  end

  assign wdata = lane_q;

  // Output FIFO
  logic [8*CH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   count;
  logic [8*CH-1:0] head_q, head_nxt;
  logic            ovf_q, full, pop, push_ok, ovf_set;

  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    pop      = (count != '0) && o_ready;
    // When full, a push only fits if the head leaves in the same cycle.
    push_ok  = vld3 && (!full || pop);
    ovf_set  = vld3 && full && !pop;
    rd_nxt   = pop ? rd_ptr + AW'(1) : rd_ptr;
    // Bypass: if the next head is the slot being written now, memory still holds stale data.
    head_nxt = (push_ok && (wr_ptr == rd_nxt)) ? wdata : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      vld3   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      vld1   <= i_valid;
      vld2   <= vld1;
      vld3   <= vld2;
      rd_ptr <= rd_nxt;
      head_q <= head_nxt;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      // A new drop outranks a clear in the same cycle.
      if (ovf_set)        ovf_q <= 1'b1;
      else if (i_clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign o_data     = head_q;
  assign o_valid    = (count != '0);
  assign o_overflow = ovf_q;
  assign o_count    = count;

endmodule
